// File: rtl/disp_pkg.sv
// Shared definitions for the display command dispatcher: command word field
// positions, control codes, blanking default and the dispatcher state type.
package disp_pkg;

  localparam int COMP_MSB    = 31;
  localparam int COMP_LSB    = 26;
  localparam int CHILD_MSB   = 25;
  localparam int CHILD_LSB   = 21;
  localparam int CTRL_MSB    = 20;
  localparam int CTRL_LSB    = 17;
  localparam int DTYPE_MSB   = 16;
  localparam int DTYPE_LSB   = 14;
  localparam int BUFSEL_BIT  = 13;
  localparam int PAYLOAD_MSB = 12;
  localparam int PAYLOAD_LSB = 0;

  localparam logic [3:0] CTRL_FLUSH  = 4'hF;
  localparam logic [3:0] CTRL_UPDATE = 4'h1;

  localparam logic [9:0] VBLANK_START_DEF = 10'd480;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_VB = 2'd2
  } disp_state_e;

  function automatic logic isFlush(input logic [31:0] word);
    return word[CTRL_MSB:CTRL_LSB] == CTRL_FLUSH;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead synchronous FIFO of 32-bit command words; DEPTH must be a power
// of two so the pointers wrap naturally.
module cmd_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              din,
  output logic [31:0]              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q;
  logic          doPush, doPop;

  assign full   = count_q == (AW+1)'(DEPTH);
  assign empty  = count_q == '0;
  assign count  = count_q;
  assign dout   = mem_q[rdPtr_q];
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cmd_dispatch.sv
// Queues CPU command words and replays them onto the display command bus,
// holding buffer-swap words for vertical blanking. Counters: CMD_DISPATCH_STATS_EN.
module cmd_dispatch
  import disp_pkg::*;
#(
  parameter int         DEPTH        = 16,
  parameter logic [9:0] VBLANK_START = VBLANK_START_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic        address,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] fillCount;
  logic          fifoFull, fifoEmpty;
  logic          pushSel, pushReq, popReq;
  logic [31:0]   headWord;
  logic          issueFlush;
  logic [15:0]   statHi;

  disp_state_e   state_q, state_d;
  logic [31:0]   cmdOut_q, cmdOut_d;
  logic          swapped_q, swapped_d;
  logic          frontSel_q, frontSel_d;

  assign pushSel     = chipselect & write & ~address;
  assign pushReq     = pushSel & ~fifoFull;
  assign waitrequest = pushSel & fifoFull;
  assign cmd_out     = cmdOut_q;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pushReq),
    .pop   (popReq),
    .din   (writedata),
    .dout  (headWord),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fillCount)
  );

  always_comb begin
    state_d    = state_q;
    cmdOut_d   = 32'h0;
    popReq     = 1'b0;
    issueFlush = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) state_d = ISSUE;
      end
      ISSUE: begin
        if (fifoEmpty) begin
          state_d = IDLE;
        end else if (isFlush(headWord)) begin
          state_d = WAIT_VB;
        end else begin
          popReq   = 1'b1;
          cmdOut_d = headWord;
          // Stay in ISSUE if a new word lands as the last one leaves.
          if (fillCount == CW'(1) && !pushReq) state_d = IDLE;
        end
      end
      WAIT_VB: begin
        if (vcount >= VBLANK_START && !swapped_q) begin
          popReq     = 1'b1;
          cmdOut_d   = headWord;
          issueFlush = 1'b1;
          state_d    = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase

    swapped_d  = swapped_q;
    if (issueFlush)         swapped_d = 1'b1;
    else if (vcount == '0)  swapped_d = 1'b0;
    frontSel_d = issueFlush ? headWord[BUFSEL_BIT] : frontSel_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cmdOut_q   <= 32'h0;
      swapped_q  <= 1'b0;
      frontSel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmdOut_q   <= cmdOut_d;
      swapped_q  <= swapped_d;
      frontSel_q <= frontSel_d;
    end
  end

`ifdef CMD_DISPATCH_STATS_EN
  logic [15:0] frameCount_q, frameCount_d;
  logic [15:0] stallCount_q, stallCount_d;

  always_comb begin
    frameCount_d = frameCount_q + {15'd0, issueFlush};
    stallCount_d = stallCount_q;
    if (chipselect && write && address)
      stallCount_d = 16'h0;
    else if (waitrequest && stallCount_q != 16'hFFFF)
      stallCount_d = stallCount_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frameCount_q <= 16'h0;
      stallCount_q <= 16'h0;
    end else begin
      frameCount_q <= frameCount_d;
      stallCount_q <= stallCount_d;
    end
  end

  assign statHi = frameCount_q;
`else
  assign statHi = 16'h0;
`endif

  assign readdata = (chipselect && read && address)
                  ? {statHi, 6'b0, frontSel_q, state_q == WAIT_VB, 8'(fillCount)}
                  : 32'h0;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch: a per-cycle vector table for the basic
// issue/flush path, plus hand-written FIFO-full, frame-pacing and reset sequences.
module tb_cmd_dispatch;
  import disp_pkg::*;

`ifdef CMD_DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect, write, read, address;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [9:0]  vcount;
  logic [31:0] cmd_out;

  int          checks = 0;
  int          errors = 0;
  int          expFlush = 0;
  logic [31:0] seen[$];

  cmd_dispatch #(.DEPTH(16), .VBLANK_START(10'd480)) dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .vcount      (vcount),
    .cmd_out     (cmd_out)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        cs, wr, rd, addr;
    logic [31:0] wdata;
    logic [9:0]  vc;
    logic [31:0] expCmd;
    logic        expWait;
    logic [31:0] expRdLo;
    logic [15:0] expFrames;
  } vec_t;

  vec_t tbl[16];

  localparam logic [31:0] W0 = 32'h2420_4005;
  localparam logic [31:0] U1 = 32'h0402_0011;
  localparam logic [31:0] FL = 32'h001E_2000;
  localparam logic [31:0] U2 = 32'h0802_0022;

  function automatic vec_t mkVec(input logic cs, input logic wr, input logic rd,
                                 input logic addr, input logic [31:0] wdata,
                                 input logic [9:0] vc, input logic [31:0] expCmd,
                                 input logic expWait, input logic [31:0] expRdLo,
                                 input logic [15:0] expFrames);
    vec_t v;
    v.cs = cs; v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.vc = vc;
    v.expCmd = expCmd; v.expWait = expWait; v.expRdLo = expRdLo; v.expFrames = expFrames;
    return v;
  endfunction

  function automatic logic [31:0] withFrames(input logic [31:0] lo, input logic [15:0] fr);
    return STATS ? {fr, lo[15:0]} : lo;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    chipselect = v.cs;
    write      = v.wr;
    read       = v.rd;
    address    = v.addr;
    writedata  = v.wdata;
    vcount     = v.vc;
  endtask

  task automatic driveIdle();
    chipselect = 1'b0; write = 1'b0; read = 1'b0; address = 1'b0; writedata = 32'h0;
  endtask

  task automatic driveRead();
    chipselect = 1'b1; write = 1'b0; read = 1'b1; address = 1'b1; writedata = 32'h0;
  endtask

  task automatic drivePush(input logic [31:0] w);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = 1'b0; writedata = w;
  endtask

  task automatic pushWord(input logic [31:0] w);
    int n;
    @(negedge clk);
    drivePush(w);
    #1;
    n = 0;
    while (waitrequest && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) checkOutput("push stall bound", {31'b0, waitrequest}, 32'h0);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (cmd_out != 32'h0) seen.push_back(cmd_out);
    end
  endtask

  task automatic readStatus(input string name, input logic [31:0] exp);
    @(negedge clk);
    driveRead();
    #1;
    checkOutput(name, readdata, exp);
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] drainExp[17];
    int          idx;
    logic        pushing, accepted;

    tbl[0]  = mkVec(1, 1, 0, 0, W0,           10'd100, 32'h0, 0, 32'h000, 16'd0);
    tbl[1]  = mkVec(1, 0, 1, 1, 32'h0,        10'd100, 32'h0, 0, 32'h001, 16'd0);
    tbl[2]  = mkVec(0, 0, 0, 0, 32'h0,        10'd100, 32'h0, 0, 32'h000, 16'd0);
    tbl[3]  = mkVec(1, 0, 1, 1, 32'h0,        10'd100, W0,    0, 32'h000, 16'd0);
    tbl[4]  = mkVec(1, 1, 0, 1, 32'hDEAD_BEEF, 10'd100, 32'h0, 0, 32'h000, 16'd0);
    tbl[5]  = mkVec(1, 1, 0, 0, U1,           10'd200, 32'h0, 0, 32'h000, 16'd0);
    tbl[6]  = mkVec(1, 1, 0, 0, FL,           10'd200, 32'h0, 0, 32'h000, 16'd0);
    tbl[7]  = mkVec(1, 1, 0, 0, U2,           10'd200, 32'h0, 0, 32'h000, 16'd0);
    tbl[8]  = mkVec(1, 0, 1, 1, 32'h0,        10'd200, U1,    0, 32'h002, 16'd0);
    tbl[9]  = mkVec(1, 0, 1, 1, 32'h0,        10'd200, 32'h0, 0, 32'h102, 16'd0);
    tbl[10] = mkVec(0, 0, 0, 0, 32'h0,        10'd479, 32'h0, 0, 32'h000, 16'd0);
    tbl[11] = mkVec(1, 0, 1, 1, 32'h0,        10'd479, 32'h0, 0, 32'h102, 16'd0);
    tbl[12] = mkVec(0, 0, 0, 0, 32'h0,        10'd480, 32'h0, 0, 32'h000, 16'd0);
    tbl[13] = mkVec(1, 0, 1, 1, 32'h0,        10'd480, FL,    0, 32'h201, 16'd1);
    tbl[14] = mkVec(1, 0, 1, 1, 32'h0,        10'd481, U2,    0, 32'h200, 16'd1);
    tbl[15] = mkVec(0, 0, 0, 0, 32'h0,        10'd481, 32'h0, 0, 32'h000, 16'd0);

    // Reset state
    driveIdle();
    vcount = 10'd100;
    reset  = 1'b0;
    repeat (2) @(negedge clk);
    drivePush(32'h1234_5678);
    #1;
    checkOutput("reset waitrequest", {31'b0, waitrequest}, 32'h0);
    checkOutput("reset cmd_out", cmd_out, 32'h0);
    @(negedge clk);
    driveRead();
    #1;
    checkOutput("reset readdata", readdata, 32'h0);
    @(negedge clk);
    driveIdle();
    reset = 1'b1;

    // Cycle-by-cycle vector table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      applyStimulus(tbl[i]);
      #1;
      checkOutput($sformatf("vec%0d cmd_out", i), cmd_out, tbl[i].expCmd);
      checkOutput($sformatf("vec%0d waitrequest", i), {31'b0, waitrequest}, {31'b0, tbl[i].expWait});
      checkOutput($sformatf("vec%0d readdata", i), readdata,
                  withFrames(tbl[i].expRdLo, tbl[i].expFrames));
    end
    expFlush = 1;

    // FIFO full behind a blocked flush, then drain in order
    vcount = 10'd10;
    drainExp[0] = 32'h001E_0000;
    pushWord(drainExp[0]);
    for (int k = 1; k < 16; k++) begin
      drainExp[k] = 32'h0002_0000 | 32'(k);
      pushWord(drainExp[k]);
    end
    drainExp[16] = 32'h0002_0011;
    readStatus("full status", withFrames(32'h310, 16'(expFlush)));
    @(negedge clk);
    drivePush(drainExp[16]);
    #1;
    checkOutput("full waitrequest", {31'b0, waitrequest}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("full hold wait%0d", k), {31'b0, waitrequest}, 32'h1);
      checkOutput($sformatf("full hold cmd%0d", k), cmd_out, 32'h0);
    end
    @(negedge clk);
    vcount = 10'd0;
    #1;
    checkOutput("full wait line0", {31'b0, waitrequest}, 32'h1);
    @(negedge clk);
    vcount = 10'd480;
    #1;
    expFlush++;
    pushing  = 1'b1;
    accepted = !waitrequest;
    idx      = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (cmd_out != 32'h0) begin
        if (idx < 17) checkOutput($sformatf("drain word%0d", idx), cmd_out, drainExp[idx]);
        else          checkOutput("drain extra word", cmd_out, 32'h0);
        idx++;
      end
      if (accepted) begin
        driveIdle();
        pushing  = 1'b0;
        accepted = 1'b0;
      end
      if (pushing && !waitrequest) accepted = 1'b1;
    end
    driveIdle();
    checkOutput("drain count", 32'(idx), 32'd17);

    // Two flushes in one blanking interval
    @(negedge clk);
    vcount = 10'd0;
    @(negedge clk);
    vcount = 10'd480;
    pushWord(FL);
    pushWord(32'h001E_0000);
    @(negedge clk);
    driveIdle();
    seen.delete();
    runCycles(10);
    expFlush++;
    checkOutput("vb1 issued count", 32'(seen.size()), 32'd1);
    checkOutput("vb1 first flush", seen.size() > 0 ? seen[0] : 32'h0, FL);
    readStatus("vb1 pending status", withFrames(32'h301, 16'(expFlush)));
    driveIdle();
    seen.delete();
    vcount = 10'd100;
    runCycles(3);
    vcount = 10'd0;
    runCycles(2);
    vcount = 10'd480;
    runCycles(6);
    expFlush++;
    checkOutput("vb2 issued count", 32'(seen.size()), 32'd1);
    checkOutput("vb2 second flush", seen.size() > 0 ? seen[0] : 32'h0, 32'h001E_0000);
    readStatus("frame count status", withFrames(32'h000, 16'(expFlush)));

    // Reset with queued words and a pending flush
    vcount = 10'd100;
    pushWord(32'h041E_0001);
    for (int k = 1; k <= 4; k++) pushWord(32'h0002_00A0 | 32'(k));
    @(negedge clk);
    driveIdle();
    seen.delete();
    runCycles(3);
    checkOutput("pre-reset issued", 32'(seen.size()), 32'd0);
    readStatus("pre-reset status", withFrames(32'h105, 16'(expFlush)));
    @(negedge clk);
    reset = 1'b0;
    driveRead();
    #1;
    checkOutput("in-reset readdata", readdata, 32'h0);
    checkOutput("in-reset cmd_out", cmd_out, 32'h0);
    @(negedge clk);
    drivePush(32'h0002_0BAD);
    #1;
    checkOutput("in-reset waitrequest", {31'b0, waitrequest}, 32'h0);
    @(negedge clk);
    driveIdle();
    reset  = 1'b1;
    vcount = 10'd480;
    seen.delete();
    runCycles(8);
    checkOutput("post-reset issued", 32'(seen.size()), 32'd0);
    readStatus("post-reset status", 32'h0);
    expFlush = 0;

    // First blanking after reset may swap without a line-0 pass
    pushWord(FL);
    @(negedge clk);
    driveIdle();
    seen.delete();
    runCycles(6);
    expFlush++;
    checkOutput("post-reset swap count", 32'(seen.size()), 32'd1);
    checkOutput("post-reset swap word", seen.size() > 0 ? seen[0] : 32'h0, FL);
    readStatus("post-reset swap status", withFrames(32'h200, 16'(expFlush)));
    @(negedge clk);
    driveIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
